// File: rtl/uart_tx_fifo.sv
// 8-bit UART transmitter fed by a byte FIFO; frames are sent LSB first, back to back.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
   parameter int unsigned p_fifo_depth = 16,
   parameter int unsigned p_stop_bits  = 1
) (
   input  logic                              clk_50m,
   input  logic                              rst,
   input  logic [31:0]                       scaler,
   input  logic                              wr_en,
   input  logic [7:0]                        wr_data,
   output logic                              full,
   output logic                              empty,
   output logic [$clog2(p_fifo_depth):0]     level,
   output logic                              ovf,
   output logic                              busy,
   output logic                              tx
);

   localparam int unsigned AW = $clog2(p_fifo_depth);
   localparam logic [AW:0] LP_PTR_ONE   = 1;
   localparam logic        LP_LAST_STOP = (p_stop_bits == 2) ? 1'b1 : 1'b0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [7:0]  r_mem [p_fifo_depth];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        r_ovf;
   logic [2:0]  r_state;
   logic [31:0] r_cnt;
   logic [31:0] r_scl;
   logic [7:0]  r_shift;
   logic [2:0]  r_idx;
   logic        r_stop_idx;
   logic        r_tx;
`ifdef UART_TX_PARITY_EN
   logic        r_par;
`endif

   logic [AW:0] w_level;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_tick;
   logic [7:0]  w_head;

   // Pointers carry an extra wrap bit, so occupancy never exceeds depth and its MSB means full.
   assign w_level = r_wptr - r_rptr;
   assign w_full  = w_level[AW];
   assign w_empty = (r_wptr == r_rptr);
   assign w_push  = wr_en && !w_full;
   assign w_tick  = (r_cnt == r_scl);
   assign w_head  = r_mem[r_rptr[AW-1:0]];
   assign w_pop   = !w_empty &&
                    ((r_state == S_IDLE) ||
                     ((r_state == S_STOP) && w_tick && (r_stop_idx == LP_LAST_STOP)));

   assign full  = w_full;
   assign empty = w_empty;
   assign level = w_level;
   assign ovf   = r_ovf;
   assign busy  = (r_state != S_IDLE);
   assign tx    = r_tx;

   always_ff @(posedge clk_50m) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + LP_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + LP_PTR_ONE;
         end
         if (wr_en && w_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tx       <= 1'b1;
         r_cnt      <= '0;
         r_scl      <= '0;
         r_shift    <= '0;
         r_idx      <= '0;
         r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else if (w_pop) begin
         // Covers both the idle start and the gapless restart at the end of STOP.
         r_state    <= S_START;
         r_tx       <= 1'b0;
         r_cnt      <= '0;
         r_scl      <= scaler;
         r_shift    <= w_head;
         r_idx      <= '0;
         r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par      <= ^w_head;
`endif
      end else if (r_state != S_IDLE) begin
         if (!w_tick) begin
            r_cnt <= r_cnt + 32'd1;
         end else begin
            r_cnt <= '0;
            case (r_state)
               S_START: begin
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
               end
               S_DATA: begin
                  if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_par;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_tx    <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end
`ifdef UART_TX_PARITY_EN
               S_PARITY: begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
               end
`endif
               S_STOP: begin
                  if (r_stop_idx == LP_LAST_STOP) begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                  end else begin
                     r_stop_idx <= 1'b1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
